// File: rtl/float_to_fixed_top.sv
// Half-precision float to signed Q8.8 converter with an embedded byte-wide data memory.
// Optional build macro FLT2FIX_ROUND_EN: round-to-nearest (ties away from zero) instead of truncation.

module float_to_fixed_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_core [DEPTH-1:0];

  // Synchronous write port; contents deliberately survive reset so preloads are kept
  always_ff @(posedge clk) begin
    if (we) begin
      mem_core[waddr] <= wdata;
    end
  end

  assign rdata = mem_core[raddr];

endmodule

module float_to_fixed_top #(
  parameter int MEM_DEPTH = 256,
  parameter int IN_ADDR   = 4,
  parameter int OUT_ADDR  = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic ack
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [AW-1:0] IN_LO  = AW'(IN_ADDR);
  localparam logic [AW-1:0] IN_HI  = AW'(IN_ADDR + 1);
  localparam logic [AW-1:0] OUT_LO = AW'(OUT_ADDR);
  localparam logic [AW-1:0] OUT_HI = AW'(OUT_ADDR + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    CONV  = 3'd3,
    WR_LO = 3'd4,
    WR_HI = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [7:0]    op_lo_r;
  logic [7:0]    op_hi_r;
  logic [15:0]   result_r;
  logic          ack_r;
  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic [7:0]    wdata_s;
  logic [AW-1:0] raddr_s;
  logic [7:0]    rdata_s;

  // Magnitude is m * 2^(E-17) in Q8.8; E >= 22 (unbiased exponent >= 7) always saturates.
  function automatic logic [15:0] flt2fix(input logic [15:0] f);
    logic        s;
    logic [4:0]  ex;
    logic [10:0] m;
    logic [4:0]  sh;
    logic [16:0] mag;
    logic [16:0] neg;
    logic [15:0] res;
    s   = f[15];
    ex  = f[14:10];
    m   = {(ex != 5'd0), f[9:0]};
    sh  = 5'd0;
    mag = 17'd0;
    neg = 17'd0;
    if (ex >= 5'd22) begin
      res = s ? 16'h8000 : 16'h7FFF;
    end else begin
      if (ex >= 5'd17) begin
        sh  = ex - 5'd17;
        mag = {6'd0, m} << sh;
      end else begin
        sh = 5'd17 - ex;
        if (sh >= 5'd11) begin
          mag = 17'd0;
        end else begin
          mag = {6'd0, (m >> sh)};
`ifdef FLT2FIX_ROUND_EN
          // The last shifted-out bit decides the rounding increment
          mag = mag + {16'd0, (|(m & (11'd1 << (sh - 5'd1))))};
`endif
        end
      end
      if (s) begin
        neg = 17'd0 - mag;
        res = (mag > 17'h08000) ? 16'h8000 : neg[15:0];
      end else begin
        res = (mag > 17'h07FFF) ? 16'h7FFF : mag[15:0];
      end
    end
    return res;
  endfunction

  float_to_fixed_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) dm (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Next-state and memory port control
  always_comb begin
    state_s = state_r;
    we_s    = 1'b0;
    waddr_s = OUT_LO;
    wdata_s = result_r[7:0];
    raddr_s = IN_LO;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RD_LO;
        end else begin
          state_s = IDLE;
        end
      end
      RD_LO: begin
        raddr_s = IN_LO;
        state_s = RD_HI;
      end
      RD_HI: begin
        raddr_s = IN_HI;
        state_s = CONV;
      end
      CONV: begin
        state_s = WR_LO;
      end
      WR_LO: begin
        we_s    = 1'b1;
        waddr_s = OUT_LO;
        wdata_s = result_r[7:0];
        state_s = WR_HI;
      end
      WR_HI: begin
        we_s    = 1'b1;
        waddr_s = OUT_HI;
        wdata_s = result_r[15:8];
        state_s = DONE;
      end
      DONE: begin
        if (start) begin
          state_s = RD_LO;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, operand capture, conversion result and registered ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      op_lo_r  <= 8'd0;
      op_hi_r  <= 8'd0;
      result_r <= 16'd0;
      ack_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      ack_r   <= (state_s == DONE);
      if (state_r == RD_LO) begin
        op_lo_r <= rdata_s;
      end
      if (state_r == RD_HI) begin
        op_hi_r <= rdata_s;
      end
      if (state_r == CONV) begin
        result_r <= flt2fix({op_hi_r, op_lo_r});
      end
    end
  end

  assign ack = ack_r;

endmodule

// File: tb/tb_float_to_fixed_top.sv
// Self-checking bench for float_to_fixed_top: directed vectors, real-arithmetic model, per-cycle ack check.
// Honours FLT2FIX_ROUND_EN when the same macro is given to the bench build.

module tb_float_to_fixed_top;

  logic clk;
  logic reset;
  logic start;
  logic ack;

  int n_chk;
  int n_pass;
  bit chk_en;

  logic exp_ack;
  bit   inflight;
  int   cnt;

  float_to_fixed_top #(
    .MEM_DEPTH (256),
    .IN_ADDR   (4),
    .OUT_ADDR  (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ack   (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value of a half-precision number times 256, from plain real arithmetic
  function automatic logic [15:0] model(input logic [15:0] f);
    int  ex;
    int  m;
    int  mag;
    real v;
    ex = int'(f[14:10]);
    m  = (ex != 0) ? (1024 + int'(f[9:0])) : int'(f[9:0]);
    if (ex >= 22) return f[15] ? 16'h8000 : 16'h7FFF;
    v = real'(m) * (2.0 ** real'(ex - 17));
`ifdef FLT2FIX_ROUND_EN
    mag = (ex <= 6) ? 0 : $rtoi(v + 0.5);
`else
    mag = $rtoi(v);
`endif
    if (!f[15] && mag > 32767) return 16'h7FFF;
    if (f[15] && mag > 32768) return 16'h8000;
    if (f[15]) mag = -mag;
    return mag[15:0];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Timing model: ack is due six edges after an accepted start and stays until the next one
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight = 1'b0;
      cnt      = 0;
      exp_ack  = 1'b0;
    end else if (start && !inflight) begin
      inflight = 1'b1;
      cnt      = 5;
      exp_ack  = 1'b0;
    end else if (inflight) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        inflight = 1'b0;
        exp_ack  = 1'b1;
      end
    end
  end

  // Per-cycle ack comparison against the timing model
  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (ack === exp_ack) begin
        n_pass++;
      end else begin
        $display("FAIL ack_cycle @%0t: got %b, expected %b", $time, ack, exp_ack);
      end
    end
  end

  task automatic run_conv(input logic [15:0] op, input logic [15:0] lit, input bit busy);
    int          lat;
    logic [15:0] got;
    logic [15:0] mdl;
    @(negedge clk);
    dut.dm.mem_core[4] = op[7:0];
    dut.dm.mem_core[5] = op[15:8];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    check("ack_low_after_start", {15'd0, ack}, 16'd0);
    while (ack !== 1'b1 && lat < 20) begin
      start = busy && (lat == 2);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("latency", lat[15:0], 16'd6);
    got = {dut.dm.mem_core[7], dut.dm.mem_core[6]};
    mdl = model(op);
    check("model_pin", mdl, lit);
    check("result_vs_model", got, mdl);
    check("result_vs_literal", got, lit);
  endtask

  logic [15:0] ops  [16];
  logic [15:0] exps [16];

  initial begin
    logic [2:0]  st;
    logic [15:0] saved;
    int          lat;

    ops[0]  = 16'h0000; exps[0]  = 16'h0000;
    ops[1]  = 16'h3C00; exps[1]  = 16'h0100;
    ops[2]  = 16'h3E00; exps[2]  = 16'h0180;
    ops[3]  = 16'h4B00; exps[3]  = 16'h0E00;
    ops[4]  = 16'hC200; exps[4]  = 16'hFD00;
    ops[5]  = 16'hBC00; exps[5]  = 16'hFF00;
    ops[6]  = 16'h8000; exps[6]  = 16'h0000;
    ops[7]  = 16'h1A00; exps[7]  = 16'h0000;
`ifdef FLT2FIX_ROUND_EN
    ops[8]  = 16'h9E00; exps[8]  = 16'hFFFE;
`else
    ops[8]  = 16'h9E00; exps[8]  = 16'hFFFF;
`endif
    ops[9]  = 16'h6300; exps[9]  = 16'h7FFF;
    ops[10] = 16'h7B80; exps[10] = 16'h7FFF;
    ops[11] = 16'hE300; exps[11] = 16'h8000;
    ops[12] = 16'hFB80; exps[12] = 16'h8000;
    ops[13] = 16'h7C00; exps[13] = 16'h7FFF;
    ops[14] = 16'h57FF; exps[14] = 16'h7FF0;
    ops[15] = 16'hD7FF; exps[15] = 16'h8010;

    n_chk  = 0;
    n_pass = 0;
    chk_en = 1'b0;
    start  = 1'b0;
    reset  = 1'b1;
    #2 reset = 1'b0;
    dut.dm.mem_core[3] = 8'hA5;
    dut.dm.mem_core[8] = 8'h5A;
    repeat (3) @(negedge clk);
    check("reset_ack", {15'd0, ack}, 16'd0);
    st = dut.state_r;
    check("reset_state_idle", {13'd0, st}, 16'd0);
    reset  = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_conv(ops[i], exps[i], 1'b0);
    end
    // Start pulse while busy must be ignored
    run_conv(16'h3E00, 16'h0180, 1'b1);
    run_conv(16'hC200, 16'hFD00, 1'b1);

    // Abort in CONV: outputs from the previous run must stay put
    saved = {dut.dm.mem_core[7], dut.dm.mem_core[6]};
    @(negedge clk);
    dut.dm.mem_core[4] = 8'h00;
    dut.dm.mem_core[5] = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (lat < 3) begin
      @(negedge clk);
      lat++;
    end
    #2 reset = 1'b0;
    #1;
    check("abort_ack", {15'd0, ack}, 16'd0);
    st = dut.state_r;
    check("abort_state_idle", {13'd0, st}, 16'd0);
    repeat (4) @(negedge clk);
    check("abort_bytes_kept", {dut.dm.mem_core[7], dut.dm.mem_core[6]}, saved);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_still_idle_ack", {15'd0, ack}, 16'd0);
    run_conv(16'h3C00, 16'h0100, 1'b0);
    run_conv(16'h4B00, 16'h0E00, 1'b0);

    check("untouched_byte3", {8'd0, dut.dm.mem_core[3]}, 16'h00A5);
    check("untouched_byte8", {8'd0, dut.dm.mem_core[8]}, 16'h005A);
    check("operand_lo_kept", {8'd0, dut.dm.mem_core[4]}, 16'h0000);
    check("operand_hi_kept", {8'd0, dut.dm.mem_core[5]}, 16'h004B);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/float_to_fixed_top.md
Name: float_to_fixed_top

Overview:
- Self-contained conversion engine with an embedded byte-wide data memory.
- On a start pulse it reads an IEEE-754 half-precision float from memory bytes 5:4 and converts it to signed two's-complement Q8.8 fixed point.
- It writes the result to bytes 7:6 and raises ack.
- Benches load operands and read results through backdoor access to the memory array.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words in the internal data memory.
- IN_ADDR, 4, address of the operand low byte; the high byte is at IN_ADDR+1.
- OUT_ADDR, 6, address of the result low byte; the high byte is at OUT_ADDR+1.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request pulse, sampled on a rising edge of clk.
- ack  output  1  done flag; high once the result is stored.

Behaviour:
- Internal memory:
  - Instance name dm; storage array mem_core[MEM_DEPTH-1:0] of 8 bits each.
  - Synchronous write, combinational read.
  - Not cleared by reset, so backdoor preloads survive reset.
- Reset (reset=0, asynchronous): FSM goes to IDLE, ack=0, all internal registers are cleared.
- FSM states: IDLE -> RD_LO -> RD_HI -> CONV -> WR_LO -> WR_HI -> DONE.
  - One state per clock.
  - start=1 in IDLE or DONE moves to RD_LO and clears ack on the same edge.
  - start is ignored in every other state.
  - ack=1 only in DONE, which is entered 6 clocks after the edge that sampled start. ack holds until the next start or reset.
- Operand: f = {mem[IN_ADDR+1], mem[IN_ADDR]}, with s=f[15], E=f[14:10], F=f[9:0].
- Decode:
  - m = {(E!=0), F}, 11 bits (hidden bit restored; E=0 gives a subnormal with hidden bit 0).
  - e = E-15, signed.
- Magnitude in Q8.8: mag = m * 2^(e-2).
  - e>=2: left shift by e-2.
  - e<2: logical right shift by 2-e, truncating.
  - Shift of 11 or more yields 0.
- Saturation when e>=7, which includes E=31 (Inf/NaN):
  - s=0 -> 0x7FFF.
  - s=1 -> 0x8000.
- Otherwise: result = s ? -mag : mag, as 16-bit two's complement. This truncates toward zero; negative zero (0x8000) gives 0x0000.
- Store: result[7:0] to mem[OUT_ADDR] in WR_LO; result[15:8] to mem[OUT_ADDR+1] in WR_HI.
- No other memory locations are written.
- Reset mid-operation: aborts immediately, ack=0. Bytes already written are kept; the memory is not rolled back.
- Back-to-back use: after DONE, a new start re-reads the operand bytes. Previous output bytes are simply overwritten.

Optional Feature:
- Macro FLT2FIX_ROUND_EN.
- Defined:
  - Right-shifted magnitudes round to nearest, ties away from zero, using the last shifted-out bit.
  - A rounding carry that pushes mag above 0x7FFF (positive) or 0x8000 (negative) saturates as above.
  - Sign is applied after rounding.
- Undefined: pure truncation toward zero as specified above.
- Saturation, latency and ack timing are identical in both builds.

Test Plan:
- Exact conversions: operand 0x0000 -> result 0x0000; 0x3C00 (1.0) -> 0x0100; 0x3E00 (1.5) -> 0x0180; 0x4B00 (14.0) -> 0x0E00. ack rises 6 clocks after start in each case.
- Negative and signed zero: 0xC200 (-3.0) -> 0xFD00; 0xBC00 (-1.0) -> 0xFF00; 0x8000 -> 0x0000.
- Truncation toward zero: 0x1A00 (1.5*2^-9) -> 0x0000; 0x9E00 (-1.5*2^-8) -> 0xFFFF. With FLT2FIX_ROUND_EN the second case gives 0xFFFE.
- Saturation: 0x6300 -> 0x7FFF; 0x7B80 -> 0x7FFF; 0xE300 -> 0x8000; 0xFB80 -> 0x8000; 0x7C00 (Inf) -> 0x7FFF.
- Handshake:
  - start pulsed while busy does not change latency or result.
  - start in DONE drops ack on the next edge and reconverts a new backdoor operand.
- Reset: drive reset low in CONV -> ack=0 and the FSM is in IDLE. Bytes 6/7 are unchanged from their prior values. A following start completes normally.
